// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrated front end for the single QSPI memory port.
// Five masters (i_read, d_read, d_write, u_read, u_write) each buffer one
// pending transaction. Requests are issued to qspi_if one at a time, and
// completions are routed back to the owning master. A WAIT-state watchdog
// releases the owner if the downstream side never completes.
module mem_arbiter #(
    parameter int TMO_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_read_req,
    input  logic        i_read_w,
    input  logic        i_read_hw,
    input  logic [31:0] i_read_adr,
    input  logic        d_read_req,
    input  logic        d_read_w,
    input  logic        d_read_hw,
    input  logic [31:0] d_read_adr,
    input  logic        d_write_req,
    input  logic        d_write_w,
    input  logic        d_write_hw,
    input  logic [31:0] d_write_adr,
    input  logic [31:0] d_write_data,
    input  logic        u_read_req,
    input  logic        u_read_w,
    input  logic [31:0] u_read_adr,
    input  logic        u_write_req,
    input  logic        u_write_w,
    input  logic [31:0] u_write_adr,
    input  logic [31:0] u_write_data,
    output logic        i_read_valid,
    output logic        d_read_valid,
    output logic        u_read_valid,
    output logic        d_write_finish,
    output logic        u_write_finish,
    output logic        read_req,
    output logic        read_w,
    output logic        read_hw,
    output logic [31:0] read_adr,
    output logic        write_req,
    output logic        write_w,
    output logic        write_hw,
    output logic [31:0] write_adr,
    output logic [31:0] write_data,
    input  logic        read_valid,
    input  logic        write_finish,
    output logic        busy,
    output logic [2:0]  grant_id,
    output logic        timeout_err,
    output logic        overrun_err,
    input  logic        err_clr
);

    // Master index order; grant_id is index + 1.
    localparam int         NM       = 5;
    localparam logic [2:0] M_IREAD  = 3'd0;
    localparam logic [2:0] M_DREAD  = 3'd1;
    localparam logic [2:0] M_DWRITE = 3'd2;
    localparam logic [2:0] M_UREAD  = 3'd3;
    localparam logic [2:0] M_UWRITE = 3'd4;
    localparam logic       GRP_CPU  = 1'b0;
    localparam logic       GRP_UART = 1'b1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t state_reg, state_next;

    // Request inputs gathered into vectors indexed by master.
    logic [NM-1:0] req_vec, w_vec, hw_vec;
    logic [31:0]   adr_vec  [NM];
    logic [31:0]   data_vec [NM];

    // Per-master pending buffer.
    logic [NM-1:0] pend_reg, w_reg, hw_reg;
    logic [31:0]   adr_reg  [NM];
    logic [31:0]   data_reg [NM];

    logic [NM-1:0] done_vec, accept_vec, drop_vec;

    // Arbitration and ownership.
    logic          cpu_any, uart_any, pick_uart;
    logic [2:0]    cpu_idx, uart_idx, win_idx;
    logic          win_is_write, own_is_write;
    logic [2:0]    own_reg;
    logic [2:0]    grant_id_reg;
    logic          last_group_reg;

    // Handshake decode and watchdog.
    logic             grant_fire, cmpl_hit, tmo_fire, deliver;
    logic [TMO_W-1:0] tmo_cnt_reg;

    // Downstream attribute registers, held from ISSUE through WAIT.
    logic        read_w_reg, read_hw_reg, write_w_reg, write_hw_reg;
    logic [31:0] read_adr_reg, write_adr_reg, write_data_reg;
    logic        timeout_err_reg, overrun_err_reg;

    assign req_vec = {u_write_req, u_read_req, d_write_req, d_read_req, i_read_req};
    assign w_vec   = {u_write_w, u_read_w, d_write_w, d_read_w, i_read_w};
    // UART masters have no halfword size.
    assign hw_vec  = {1'b0, 1'b0, d_write_hw, d_read_hw, i_read_hw};

    assign adr_vec[M_IREAD]   = i_read_adr;
    assign adr_vec[M_DREAD]   = d_read_adr;
    assign adr_vec[M_DWRITE]  = d_write_adr;
    assign adr_vec[M_UREAD]   = u_read_adr;
    assign adr_vec[M_UWRITE]  = u_write_adr;
    assign data_vec[M_IREAD]  = 32'd0;
    assign data_vec[M_DREAD]  = 32'd0;
    assign data_vec[M_DWRITE] = d_write_data;
    assign data_vec[M_UREAD]  = 32'd0;
    assign data_vec[M_UWRITE] = u_write_data;

    // Per-master completion routing and request accept/drop decisions.
    // A request in the same cycle as its own completion is accepted.
    generate
        for (genvar gi = 0; gi < NM; gi++) begin : g_master
            assign done_vec[gi]   = deliver && (own_reg == 3'(gi));
            assign accept_vec[gi] = req_vec[gi] && (!pend_reg[gi] || done_vec[gi]);
            assign drop_vec[gi]   = req_vec[gi] && pend_reg[gi] && !done_vec[gi];
        end
    endgenerate

    // Capture request attributes and track pending per master.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_reg <= '0;
            w_reg    <= '0;
            hw_reg   <= '0;
            for (int m = 0; m < NM; m++) begin
                adr_reg[m]  <= '0;
                data_reg[m] <= '0;
            end
        end else begin
            for (int m = 0; m < NM; m++) begin
                if (accept_vec[m]) begin
                    pend_reg[m] <= 1'b1;
                    w_reg[m]    <= w_vec[m];
                    hw_reg[m]   <= hw_vec[m];
                    adr_reg[m]  <= adr_vec[m];
                    data_reg[m] <= data_vec[m];
                end else if (done_vec[m]) begin
                    pend_reg[m] <= 1'b0;
                end
            end
        end
    end

    // Fixed priority inside each group, round-robin between the groups.
    always_comb begin
        cpu_any  = |pend_reg[M_DWRITE:M_IREAD];
        uart_any = |pend_reg[M_UWRITE:M_UREAD];
        if (pend_reg[M_DWRITE]) begin
            cpu_idx = M_DWRITE;
        end else if (pend_reg[M_DREAD]) begin
            cpu_idx = M_DREAD;
        end else begin
            cpu_idx = M_IREAD;
        end
        uart_idx     = pend_reg[M_UWRITE] ? M_UWRITE : M_UREAD;
        pick_uart    = uart_any && (!cpu_any || (last_group_reg == GRP_CPU));
        win_idx      = pick_uart ? uart_idx : cpu_idx;
        win_is_write = (win_idx == M_DWRITE) || (win_idx == M_UWRITE);
        own_is_write = (own_reg == M_DWRITE) || (own_reg == M_UWRITE);
    end

    // Transaction state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic plus grant, completion and watchdog decode.
    always_comb begin
        state_next = state_reg;
        grant_fire = 1'b0;
        cmpl_hit   = 1'b0;
        tmo_fire   = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (|pend_reg) begin
                    grant_fire = 1'b1;
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_next = S_WAIT;
            end
            S_WAIT: begin
                // A completion of the wrong kind is simply not selected.
                cmpl_hit = own_is_write ? write_finish : read_valid;
                tmo_fire = (tmo_cnt_reg == '1);
                if (cmpl_hit || tmo_fire) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign deliver = cmpl_hit || tmo_fire;

    // Latch owner and downstream attributes at grant; release owner at delivery.
    always_ff @(posedge clk) begin
        if (rst) begin
            own_reg        <= '0;
            grant_id_reg   <= '0;
            last_group_reg <= GRP_UART;
            read_w_reg     <= 1'b0;
            read_hw_reg    <= 1'b0;
            read_adr_reg   <= '0;
            write_w_reg    <= 1'b0;
            write_hw_reg   <= 1'b0;
            write_adr_reg  <= '0;
            write_data_reg <= '0;
        end else if (grant_fire) begin
            own_reg        <= win_idx;
            grant_id_reg   <= win_idx + 3'd1;
            last_group_reg <= pick_uart;
            if (win_is_write) begin
                write_w_reg    <= w_reg[win_idx];
                write_hw_reg   <= hw_reg[win_idx];
                write_adr_reg  <= adr_reg[win_idx];
                write_data_reg <= data_reg[win_idx];
            end else begin
                read_w_reg   <= w_reg[win_idx];
                read_hw_reg  <= hw_reg[win_idx];
                read_adr_reg <= adr_reg[win_idx];
            end
        end else if (deliver) begin
            grant_id_reg <= '0;
        end
    end

    // Watchdog: cleared in ISSUE, counts WAIT cycles. It fires on the WAIT
    // cycle where the count reads all-ones, i.e. after 2^TMO_W-1 quiet cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_reg <= '0;
        end else if (state_reg == S_ISSUE) begin
            tmo_cnt_reg <= '0;
        end else if (state_reg == S_WAIT) begin
            tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
        end
    end

    // Sticky error flags; clearing wins over a simultaneous set.
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_err_reg <= 1'b0;
            overrun_err_reg <= 1'b0;
        end else if (err_clr) begin
            timeout_err_reg <= 1'b0;
            overrun_err_reg <= 1'b0;
        end else begin
            if (tmo_fire && !cmpl_hit) begin
                timeout_err_reg <= 1'b1;
            end
            if (|drop_vec) begin
                overrun_err_reg <= 1'b1;
            end
        end
    end

    assign i_read_valid   = done_vec[M_IREAD];
    assign d_read_valid   = done_vec[M_DREAD];
    assign d_write_finish = done_vec[M_DWRITE];
    assign u_read_valid   = done_vec[M_UREAD];
    assign u_write_finish = done_vec[M_UWRITE];

    assign read_req    = (state_reg == S_ISSUE) && !own_is_write;
    assign write_req   = (state_reg == S_ISSUE) && own_is_write;
    assign read_w      = read_w_reg;
    assign read_hw     = read_hw_reg;
    assign read_adr    = read_adr_reg;
    assign write_w     = write_w_reg;
    assign write_hw    = write_hw_reg;
    assign write_adr   = write_adr_reg;
    assign write_data  = write_data_reg;
    assign busy        = (state_reg != S_IDLE);
    assign grant_id    = grant_id_reg;
    assign timeout_err = timeout_err_reg;
    assign overrun_err = overrun_err_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a vector table of single transactions
// followed by hand-written multi-cycle sequences (priority, round-robin,
// overrun, same-cycle re-request, watchdog timeout, reset in WAIT).
module tb_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        i_read_req, i_read_w, i_read_hw;
    logic [31:0] i_read_adr;
    logic        d_read_req, d_read_w, d_read_hw;
    logic [31:0] d_read_adr;
    logic        d_write_req, d_write_w, d_write_hw;
    logic [31:0] d_write_adr, d_write_data;
    logic        u_read_req, u_read_w;
    logic [31:0] u_read_adr;
    logic        u_write_req, u_write_w;
    logic [31:0] u_write_adr, u_write_data;
    logic        i_read_valid, d_read_valid, u_read_valid;
    logic        d_write_finish, u_write_finish;
    logic        read_req, read_w, read_hw;
    logic [31:0] read_adr;
    logic        write_req, write_w, write_hw;
    logic [31:0] write_adr, write_data;
    logic        read_valid, write_finish;
    logic        busy;
    logic [2:0]  grant_id;
    logic        timeout_err, overrun_err, err_clr;

    mem_arbiter #(.TMO_W(4)) dut (
        .clk(clk), .rst(rst),
        .i_read_req(i_read_req), .i_read_w(i_read_w), .i_read_hw(i_read_hw), .i_read_adr(i_read_adr),
        .d_read_req(d_read_req), .d_read_w(d_read_w), .d_read_hw(d_read_hw), .d_read_adr(d_read_adr),
        .d_write_req(d_write_req), .d_write_w(d_write_w), .d_write_hw(d_write_hw),
        .d_write_adr(d_write_adr), .d_write_data(d_write_data),
        .u_read_req(u_read_req), .u_read_w(u_read_w), .u_read_adr(u_read_adr),
        .u_write_req(u_write_req), .u_write_w(u_write_w), .u_write_adr(u_write_adr),
        .u_write_data(u_write_data),
        .i_read_valid(i_read_valid), .d_read_valid(d_read_valid), .u_read_valid(u_read_valid),
        .d_write_finish(d_write_finish), .u_write_finish(u_write_finish),
        .read_req(read_req), .read_w(read_w), .read_hw(read_hw), .read_adr(read_adr),
        .write_req(write_req), .write_w(write_w), .write_hw(write_hw),
        .write_adr(write_adr), .write_data(write_data),
        .read_valid(read_valid), .write_finish(write_finish),
        .busy(busy), .grant_id(grant_id),
        .timeout_err(timeout_err), .overrun_err(overrun_err), .err_clr(err_clr)
    );

    // Completion outputs in master order (bit = grant_id - 1).
    logic [4:0] done_obs;
    assign done_obs = {u_write_finish, u_read_valid, d_write_finish, d_read_valid, i_read_valid};

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        int          mid;
        logic        w;
        logic        hw;
        logic [31:0] adr;
        logic [31:0] data;
        int          lat;
        int          e_gid;
        logic        e_w;
        logic        e_hw;
        logic [31:0] e_adr;
        logic [31:0] e_data;
        int          e_wait;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string tag, input string what, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s.%s: got 0x%08h expected 0x%08h", tag, what, act, exp);
        end
    endtask

    task automatic set_req(input int mid, input logic w, input logic hw, input logic [31:0] adr, input logic [31:0] data);
        case (mid)
            1: begin i_read_req = 1'b1; i_read_w = w; i_read_hw = hw; i_read_adr = adr; end
            2: begin d_read_req = 1'b1; d_read_w = w; d_read_hw = hw; d_read_adr = adr; end
            3: begin d_write_req = 1'b1; d_write_w = w; d_write_hw = hw; d_write_adr = adr; d_write_data = data; end
            4: begin u_read_req = 1'b1; u_read_w = w; u_read_adr = adr; end
            5: begin u_write_req = 1'b1; u_write_w = w; u_write_adr = adr; u_write_data = data; end
            default: ;
        endcase
    endtask

    task automatic clr_reqs();
        i_read_req  = 1'b0;
        d_read_req  = 1'b0;
        d_write_req = 1'b0;
        u_read_req  = 1'b0;
        u_write_req = 1'b0;
    endtask

    // Wait (bounded) for a downstream request pulse, counting negedges waited.
    task automatic wait_issue(output bit seen, output int waited);
        seen   = 1'b0;
        waited = 0;
        for (int k = 0; k < 40; k++) begin
            if (read_req || write_req) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            waited++;
        end
    endtask

    // Act as qspi_if for one transaction: check the issue, answer after lat
    // cycles (with a wrong-kind completion one cycle earlier), check routing.
    task automatic serve(input string tag, input int gid, input logic [31:0] e_adr, input logic e_w,
                         input logic e_hw, input logic [31:0] e_data, input int lat, input int e_wait,
                         input bit rp, input logic [31:0] rp_adr);
        bit         seen;
        int         waited;
        bit         is_wr;
        logic [4:0] e_done;
        is_wr  = (gid == 3) || (gid == 5);
        e_done = 5'(1 << (gid - 1));
        wait_issue(seen, waited);
        chk(tag, "issue_seen", 32'(seen), 32'd1);
        if (seen) begin
            chk(tag, "issue_latency", 32'(waited), 32'(e_wait));
            chk(tag, "grant_id", 32'(grant_id), 32'(gid));
            chk(tag, "req_kind", {30'd0, write_req, read_req}, is_wr ? 32'd2 : 32'd1);
            if (is_wr) begin
                chk(tag, "write_adr", write_adr, e_adr);
                chk(tag, "write_size", {30'd0, write_w, write_hw}, {30'd0, e_w, e_hw});
                chk(tag, "write_data", write_data, e_data);
            end else begin
                chk(tag, "read_adr", read_adr, e_adr);
                chk(tag, "read_size", {30'd0, read_w, read_hw}, {30'd0, e_w, e_hw});
            end
            for (int k = 1; k <= lat; k++) begin
                @(negedge clk);
                read_valid   = 1'b0;
                write_finish = 1'b0;
                if (k == lat) begin
                    if (is_wr) write_finish = 1'b1; else read_valid = 1'b1;
                    if (rp) set_req(gid, e_w, e_hw, rp_adr, e_data);
                end else if (k == lat - 1) begin
                    if (is_wr) read_valid = 1'b1; else write_finish = 1'b1;
                end
                #1;
                if (k == 1) chk(tag, "req_single_cycle", {30'd0, write_req, read_req}, 32'd0);
                if (k == lat) chk(tag, "completion", 32'(done_obs), 32'(e_done));
                else if (k == lat - 1) chk(tag, "wrong_kind_ignored", 32'(done_obs), 32'd0);
            end
            chk(tag, "attr_held", is_wr ? write_adr : read_adr, e_adr);
            @(negedge clk);
            read_valid   = 1'b0;
            write_finish = 1'b0;
            clr_reqs();
            #1;
            chk(tag, "completion_one_cycle", 32'(done_obs), 32'd0);
            chk(tag, "grant_released", {28'd0, busy, grant_id}, 32'd0);
            $display("txn %s gid=%0d adr=0x%08h lat=%0d", tag, gid, e_adr, lat);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        bit seen;
        int waited;
        int bad;

        vecs[0] = '{2, 1'b1, 1'b0, 32'h0000_1000, 32'h0,         5, 2, 1'b1, 1'b0, 32'h0000_1000, 32'h0,         1};
        vecs[1] = '{1, 1'b0, 1'b1, 32'h0000_2002, 32'h0,         3, 1, 1'b0, 1'b1, 32'h0000_2002, 32'h0,         1};
        vecs[2] = '{3, 1'b0, 1'b0, 32'h0000_3003, 32'h1234_5678, 1, 3, 1'b0, 1'b0, 32'h0000_3003, 32'h1234_5678, 1};
        vecs[3] = '{4, 1'b1, 1'b0, 32'h0000_4000, 32'h0,         2, 4, 1'b1, 1'b0, 32'h0000_4000, 32'h0,         1};
        vecs[4] = '{5, 1'b0, 1'b1, 32'h0000_5001, 32'h0000_00A5, 4, 5, 1'b0, 1'b0, 32'h0000_5001, 32'h0000_00A5, 1};
        vecs[5] = '{3, 1'b0, 1'b1, 32'h0000_6006, 32'hCAFE_0000, 7, 3, 1'b0, 1'b1, 32'h0000_6006, 32'hCAFE_0000, 1};

        rst = 1'b1;
        err_clr = 1'b0;
        read_valid = 1'b0;
        write_finish = 1'b0;
        i_read_w = 0; i_read_hw = 0; i_read_adr = 0;
        d_read_w = 0; d_read_hw = 0; d_read_adr = 0;
        d_write_w = 0; d_write_hw = 0; d_write_adr = 0; d_write_data = 0;
        u_read_w = 0; u_read_adr = 0;
        u_write_w = 0; u_write_adr = 0; u_write_data = 0;
        clr_reqs();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset", "busy_grant", {28'd0, busy, grant_id}, 32'd0);
        chk("reset", "errors", {30'd0, timeout_err, overrun_err}, 32'd0);
        chk("reset", "reqs", {30'd0, read_req, write_req}, 32'd0);
        chk("reset", "sizes", {28'd0, read_w, read_hw, write_w, write_hw}, 32'd0);
        chk("reset", "read_adr", read_adr, 32'd0);
        chk("reset", "write_adr", write_adr, 32'd0);
        chk("reset", "write_data", write_data, 32'd0);
        chk("reset", "completions", 32'(done_obs), 32'd0);

        // Single transactions from the table.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            set_req(vecs[i].mid, vecs[i].w, vecs[i].hw, vecs[i].adr, vecs[i].data);
            @(negedge clk);
            clr_reqs();
            #1;
            chk("vec", "idle_when_pending", 32'(busy), 32'd0);
            serve($sformatf("vec%0d", i), vecs[i].e_gid, vecs[i].e_adr, vecs[i].e_w, vecs[i].e_hw,
                  vecs[i].e_data, vecs[i].lat, vecs[i].e_wait, 1'b0, 32'd0);
        end

        // CPU group priority: d_write > d_read > i_read.
        @(negedge clk);
        set_req(3, 1'b1, 1'b0, 32'h0000_0100, 32'h0BAD_F00D);
        set_req(2, 1'b1, 1'b0, 32'h0000_0200, 32'h0);
        set_req(1, 1'b1, 1'b0, 32'h0000_0300, 32'h0);
        @(negedge clk);
        clr_reqs();
        serve("prio_dw", 3, 32'h0000_0100, 1'b1, 1'b0, 32'h0BAD_F00D, 4, 1, 1'b0, 32'd0);
        serve("prio_dr", 2, 32'h0000_0200, 1'b1, 1'b0, 32'h0, 4, 1, 1'b0, 32'd0);
        serve("prio_ir", 1, 32'h0000_0300, 1'b1, 1'b0, 32'h0, 4, 1, 1'b0, 32'd0);

        // Watchdog: d_write never completes, i_read waits behind it.
        @(negedge clk);
        set_req(3, 1'b1, 1'b0, 32'h0000_9000, 32'h1111_2222);
        set_req(1, 1'b1, 1'b0, 32'h0000_9100, 32'h0);
        @(negedge clk);
        clr_reqs();
        wait_issue(seen, waited);
        chk("tmo", "issue_seen", 32'(seen), 32'd1);
        chk("tmo", "grant_id", 32'(grant_id), 32'd3);
        bad = 0;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            #1;
            if (done_obs != 5'd0 || !busy) bad++;
        end
        chk("tmo", "quiet_wait_cycles", 32'(bad), 32'd0);
        @(negedge clk);
        #1;
        chk("tmo", "owner_released", 32'(done_obs), 32'h04);
        @(negedge clk);
        #1;
        chk("tmo", "timeout_err", 32'(timeout_err), 32'd1);
        chk("tmo", "release_one_cycle", 32'(done_obs), 32'd0);
        chk("tmo", "back_to_idle", 32'(busy), 32'd0);
        serve("tmo_next", 1, 32'h0000_9100, 1'b1, 1'b0, 32'h0, 2, 1, 1'b0, 32'd0);
        chk("tmo", "timeout_sticky", 32'(timeout_err), 32'd1);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        #1;
        chk("tmo", "err_clr", 32'(timeout_err), 32'd0);

        // Reset so round-robin starts from its reset state (CPU wins first).
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        set_req(2, 1'b1, 1'b0, 32'h0000_B000, 32'h0);
        set_req(1, 1'b1, 1'b0, 32'h0000_B100, 32'h0);
        set_req(5, 1'b1, 1'b0, 32'h0000_B200, 32'hDEAD_BEEF);
        set_req(4, 1'b1, 1'b0, 32'h0000_B300, 32'h0);
        @(negedge clk);
        clr_reqs();
        serve("rr_cpu1", 2, 32'h0000_B000, 1'b1, 1'b0, 32'h0, 2, 1, 1'b0, 32'd0);
        serve("rr_uart1", 5, 32'h0000_B200, 1'b1, 1'b0, 32'hDEAD_BEEF, 2, 1, 1'b0, 32'd0);
        serve("rr_cpu2", 1, 32'h0000_B100, 1'b1, 1'b0, 32'h0, 2, 1, 1'b0, 32'd0);
        serve("rr_uart2", 4, 32'h0000_B300, 1'b1, 1'b0, 32'h0, 2, 1, 1'b0, 32'd0);

        // Overrun: second d_read while the first is pending is dropped.
        @(negedge clk);
        set_req(2, 1'b1, 1'b0, 32'h0000_7000, 32'h0);
        @(negedge clk);
        set_req(2, 1'b1, 1'b0, 32'h0000_7777, 32'h0);
        @(negedge clk);
        clr_reqs();
        #1;
        chk("ovr", "overrun_err", 32'(overrun_err), 32'd1);
        serve("ovr", 2, 32'h0000_7000, 1'b1, 1'b0, 32'h0, 3, 0, 1'b0, 32'd0);
        repeat (3) @(negedge clk);
        #1;
        chk("ovr", "dropped_not_serviced", 32'(busy), 32'd0);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        #1;
        chk("ovr", "err_clr", 32'(overrun_err), 32'd0);

        // err_clr in the same cycle as an overrun keeps the flag clear.
        @(negedge clk);
        set_req(2, 1'b1, 1'b0, 32'h0000_7100, 32'h0);
        @(negedge clk);
        set_req(2, 1'b1, 1'b0, 32'h0000_7199, 32'h0);
        err_clr = 1'b1;
        @(negedge clk);
        clr_reqs();
        err_clr = 1'b0;
        #1;
        chk("clrpri", "overrun_err", 32'(overrun_err), 32'd0);
        serve("clrpri", 2, 32'h0000_7100, 1'b1, 1'b0, 32'h0, 2, 0, 1'b0, 32'd0);

        // Request in the same cycle as the master's own completion is accepted.
        @(negedge clk);
        set_req(2, 1'b0, 1'b1, 32'h0000_8000, 32'h0);
        @(negedge clk);
        clr_reqs();
        serve("same_cyc_a", 2, 32'h0000_8000, 1'b0, 1'b1, 32'h0, 2, 1, 1'b1, 32'h0000_8800);
        serve("same_cyc_b", 2, 32'h0000_8800, 1'b0, 1'b1, 32'h0, 2, 1, 1'b0, 32'd0);
        chk("same_cyc", "no_overrun", 32'(overrun_err), 32'd0);

        // Reset asserted in WAIT abandons the transaction silently.
        @(negedge clk);
        set_req(4, 1'b1, 1'b0, 32'h0000_A000, 32'h0);
        @(negedge clk);
        clr_reqs();
        wait_issue(seen, waited);
        chk("rstwait", "issue_seen", 32'(seen), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        read_valid = 1'b1;
        #1;
        chk("rstwait", "busy_grant", {28'd0, busy, grant_id}, 32'd0);
        chk("rstwait", "read_attr", {read_adr[30:0], read_w}, 32'd0);
        chk("rstwait", "reqs", {30'd0, read_req, write_req}, 32'd0);
        chk("rstwait", "no_completion", 32'(done_obs), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rstwait", "idle_completion_ignored", 32'(done_obs), 32'd0);
        @(negedge clk);
        read_valid = 1'b0;
        set_req(2, 1'b1, 1'b0, 32'h0000_C000, 32'h0);
        @(negedge clk);
        clr_reqs();
        serve("post_reset", 2, 32'h0000_C000, 1'b1, 1'b0, 32'h0, 3, 1, 1'b0, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrated front end for the single QSPI memory port. It accepts one-cycle request pulses from three CPU masters (instruction read, data read, data write) and two UART DMA masters (read, write), buffers one pending transaction per master, and issues them one at a time to qspi_if. It routes qspi_if completions back to the owning master and recovers from a hung transaction by timeout. It sits between cpu_top/uart_top and qspi_if, in place of the plain request-OR gathering.

## Interface
- TMO_W, 16: width of the WAIT-state watchdog counter; timeout fires after 2^TMO_W-1 cycles.
- clk  in  1  system clock (single clock domain).
- rst  in  1  synchronous, active-high reset.
- i_read_req, d_read_req, d_write_req, u_read_req, u_write_req  in  1 each  request pulses.
- i_read_w/hw, d_read_w/hw, d_write_w/hw, u_read_w, u_write_w  in  1 each  access size (w=word, hw=halfword, neither=byte; UART is word or byte only).
- i_read_adr, d_read_adr, d_write_adr, u_read_adr, u_write_adr  in  32 each  byte address.
- d_write_data, u_write_data  in  32 each  write data.
- i_read_valid, d_read_valid, u_read_valid  out  1 each  read completion to the owning master.
- d_write_finish, u_write_finish  out  1 each  write completion to the owning master.
- read_req, write_req  out  1  downstream request pulses.
- read_w, read_hw, write_w, write_hw  out  1  downstream size.
- read_adr, write_adr, write_data  out  32  downstream address and data.
- read_valid, write_finish  in  1  downstream completion pulses.
- busy  out  1  state is not IDLE.
- grant_id  out  3  current owner: 0=none, 1=i_read, 2=d_read, 3=d_write, 4=u_read, 5=u_write.
- timeout_err, overrun_err  out  1  sticky error flags.
- err_clr  in  1  clears both sticky flags.

## Operation
- Per-master capture: on req pulse, set pending[m] and latch size, address and data into a per-master register. Pending is cleared when that master's completion or timeout is delivered.
- A req for a master whose pending is already set, and not being cleared that cycle, is dropped: latched attributes are unchanged and overrun_err is set.
- A req arriving in the same cycle as that master's own completion is accepted: pending stays 1 and the new attributes are latched.
- Arbitration runs in IDLE over the registered pending bits.
  - CPU group internal priority: d_write > d_read > i_read.
  - UART group internal priority: u_write > u_read.
  - Between groups: round-robin on last_group. When both groups are pending, the group not served last wins.
  - last_group updates at each grant.
- FSM IDLE -> ISSUE -> WAIT -> IDLE.
  - IDLE: if any pending, latch the winner into grant_id and go to ISSUE.
  - ISSUE: assert read_req or write_req for exactly one cycle, with the winner's latched attributes on the downstream bus. Clear the watchdog and go to WAIT.
  - WAIT: hold the downstream attributes stable.
    - Read grant: read_valid produces the owner's *_valid for the same cycle (combinational), clears pending, and returns to IDLE.
    - Write grant: write_finish is handled the same way and produces *_finish.
    - Completion of the wrong kind (read_valid during a write grant, or the reverse) is ignored.
  - Watchdog in WAIT: when the counter reaches all-ones, set timeout_err, pulse the owner's completion output for one cycle so the master is released, clear pending, and return to IDLE.
- Downstream completions outside WAIT are ignored.
- Downstream read data is not routed through this block.

## Timing
- Reset:
  - state=IDLE, all pending=0, last_group=UART (so the CPU wins the first tie).
  - grant_id=0, busy=0, timeout_err=0, overrun_err=0.
  - All req, valid and finish outputs 0; all downstream address, data and size outputs 0.
- A reset asserted mid-transaction abandons it; no completion pulse is generated.
- Minimum latency, req at cycle N:
  - N+1: pending visible and arbitration in IDLE.
  - N+2: ISSUE; downstream req high.
  - N+3: earliest WAIT cycle.
  - A completion at N+3 produces the master's valid at N+3, and IDLE at N+4.
- Back-to-back: the next grant's ISSUE is no earlier than 2 cycles after the previous completion.
- Downstream req is a single-cycle pulse; attributes are held from ISSUE through the last WAIT cycle.
- err_clr has priority over simultaneous error setting.

## Test plan
- Single d_read at adr 0x0000_1000, w=1, with read_valid 5 cycles after read_req -> read_req pulse at N+2 with read_adr=0x1000 and read_w=1; d_read_valid for one cycle coincident with read_valid; grant_id returns to 0.
- d_write, d_read and i_read pulsed in the same cycle, with 4-cycle completions -> service order d_write, d_read, i_read; each write_req/read_req carries the correct address.
- CPU and UART pending continuously -> grants alternate CPU/UART starting with CPU; u_write_data=0xDEADBEEF appears on write_data during the UART write.
- Second d_read pulse while the first is pending -> overrun_err=1; the first transaction's address is unchanged. err_clr -> overrun_err=0.
- No completion with TMO_W=4 -> after 15 WAIT cycles timeout_err=1, the owner's valid pulses once, and the next pending master is granted.
- Reset asserted in WAIT -> next cycle all outputs 0 and no completion pulse; a later request is serviced normally.
